// File: rtl/pe_result_writer_if.sv
// ----------------------------------------------------------------------------
// pe_result_writer_if : PE-side result strobe and output-memory write bus
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface pe_result_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] baseAddr;
  logic [DATA_W-1:0] resIn;
  logic              storeIn;
  logic              peDone;
  logic              memReady;
  logic              memWrEn;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;
  logic              busy;
  logic              done;
  logic              overflow;

  modport master (
    output start, baseAddr, resIn, storeIn, peDone, memReady,
    input  memWrEn, memAddr, memData, busy, done, overflow
  );

  modport slave (
    input  start, baseAddr, resIn, storeIn, peDone, memReady,
    output memWrEn, memAddr, memData, busy, done, overflow
  );
endinterface

`default_nettype wire

// File: rtl/pe_result_writer.sv
// ----------------------------------------------------------------------------
// pe_result_writer : buffers PE results in a FIFO and writes them to memory
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pe_result_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pe_result_writer_if.slave  bus
);
  localparam int c_PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_PTR_W:0]    r_count;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_overflow;
  logic                r_busy;
  logic                r_done;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (c_PTR_W+1)'(DEPTH));
  // Occupancy is zero outside RUN/DRAIN, so pops cannot leak into IDLE/DONE.
  assign w_pop   = !w_empty && bus.memReady;
  assign w_push  = bus.storeIn && (r_state == S_RUN) && (!w_full || w_pop);
  assign w_drop  = bus.storeIn &&
                   (((r_state == S_RUN) && w_full && !w_pop) || (r_state == S_DRAIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_addr     <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_RUN;
            r_busy     <= 1'b1;
            r_addr     <= bus.baseAddr;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
          end
        end
        S_RUN: begin
          if (bus.peDone) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase

      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.resIn;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_addr   <= r_addr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.memWrEn  = !w_empty;
  assign bus.memAddr  = r_addr;
  assign bus.memData  = r_mem[r_rd_ptr];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overflow = r_overflow;

endmodule

`default_nettype wire
